// File: rtl/dcache_stall_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller for the MEM stage.
// Hit loads finish in zero cycles; misses and all stores raise stall while the memory port works.
module dcache_stall_ctrl #(
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_rd,
    input  logic        req_wr,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    input  logic        flush,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_we,
    output logic [31:0] mem_req_addr,
    output logic [31:0] mem_req_wdata,
    output logic [3:0]  mem_req_be,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data
);

    localparam int WB   = $clog2(WORDS);
    localparam int IB   = $clog2(LINES);
    localparam int OFF  = WB + 2;
    localparam int TAGW = 32 - OFF - IB;

    typedef enum logic [2:0] {
        IDLE,
        FILL_REQ,
        FILL_RSP,
        WR_REQ,
        WR_RSP,
        DONE
    } state_t;

    state_t            state;
    logic [WB-1:0]     k;
    logic [LINES-1:0]  line_valid;
    logic [TAGW-1:0]   tag_mem  [LINES];
    logic [31:0]       data_mem [LINES*WORDS];

    logic [TAGW-1:0]   req_tag;
    logic [IB-1:0]     req_idx;
    logic [WB-1:0]     req_word;
    logic              hit;
    logic [31:0]       sel_word;
    logic [31:0]       merged_word;
    logic              fill_start;
    logic              store_hit;
    logic              fill_beat;
    logic              unused_addr_bits;

    assign req_tag  = req_addr[31:OFF+IB];
    assign req_idx  = req_addr[OFF+IB-1:OFF];
    assign req_word = req_addr[OFF-1:2];
    assign unused_addr_bits = ^req_addr[1:0];

    assign hit      = line_valid[req_idx] && (tag_mem[req_idx] == req_tag);
    assign sel_word = data_mem[{req_idx, req_word}];

    assign fill_start = (state == IDLE) && !req_wr && req_rd && !hit;
    assign store_hit  = (state == IDLE) && req_wr && hit;
    assign fill_beat  = (state == FILL_RSP) && mem_rsp_valid;

    always_comb begin
        merged_word = sel_word;
        for (int b = 0; b < 4; b++) begin
            if (req_be[b]) begin
                merged_word[b*8 +: 8] = req_wdata[b*8 +: 8];
            end
        end
    end

    // Tag and data arrays are deliberately left unreset; the valid bits alone gate hits.
    always_ff @(posedge clk) begin
        if (fill_start) begin
            tag_mem[req_idx] <= req_tag;
        end
        if (store_hit) begin
            data_mem[{req_idx, req_word}] <= merged_word;
        end
        if (fill_beat) begin
            data_mem[{req_idx, k}] <= mem_rsp_data;
        end
    end

    always_comb begin
        stall = 1'b0;
        rdata = '0;
        case (state)
            IDLE:    stall = req_wr | (req_rd & ~hit);
            DONE:    stall = 1'b0;
            default: stall = 1'b1;
        endcase
        if (req_rd && (hit || state == DONE)) begin
            rdata = sel_word;
        end
        if (!rst_n) begin
            stall = 1'b0;
            rdata = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            k             <= '0;
            line_valid    <= '0;
            mem_req_valid <= 1'b0;
            mem_req_we    <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wdata <= '0;
            mem_req_be    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_wr) begin
                        state         <= WR_REQ;
                        mem_req_valid <= 1'b1;
                        mem_req_we    <= 1'b1;
                        mem_req_addr  <= {req_addr[31:2], 2'b00};
                        mem_req_wdata <= req_wdata;
                        mem_req_be    <= req_be;
                    end else if (req_rd && !hit) begin
                        // Invalidate up front so a half-filled line can never hit.
                        state               <= FILL_REQ;
                        line_valid[req_idx] <= 1'b0;
                        k                   <= '0;
                        mem_req_valid       <= 1'b1;
                        mem_req_we          <= 1'b0;
                        mem_req_be          <= 4'hF;
                        mem_req_wdata       <= '0;
                        mem_req_addr        <= {req_tag, req_idx, {WB{1'b0}}, 2'b00};
                    end
                end
                FILL_REQ: begin
                    if (mem_req_ready) begin
                        state         <= FILL_RSP;
                        mem_req_valid <= 1'b0;
                    end
                end
                FILL_RSP: begin
                    if (mem_rsp_valid) begin
                        if (k == WB'(WORDS - 1)) begin
                            line_valid[req_idx] <= 1'b1;
                            state               <= DONE;
                        end else begin
                            k             <= k + 1'b1;
                            state         <= FILL_REQ;
                            mem_req_valid <= 1'b1;
                            mem_req_addr  <= {req_tag, req_idx, k + 1'b1, 2'b00};
                        end
                    end
                end
                WR_REQ: begin
                    if (mem_req_ready) begin
                        state         <= WR_RSP;
                        mem_req_valid <= 1'b0;
                    end
                end
                WR_RSP: begin
                    if (mem_rsp_valid) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
            if (flush && (state == IDLE || state == DONE)) begin
                line_valid <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dcache_stall_ctrl.sv
// Directed self-checking bench for dcache_stall_ctrl (LINES=16, WORDS=4).
// The bench plays the memory side itself and checks the pipeline and memory-port behaviour.
module tb_dcache_stall_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_rd;
    logic        req_wr;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        flush;
    logic [31:0] rdata;
    logic        stall;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_we;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_be;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;

    int compared;
    int mismatched;

    dcache_stall_ctrl #(.LINES(16), .WORDS(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_rd        (req_rd),
        .req_wr        (req_wr),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_be        (req_be),
        .flush         (flush),
        .rdata         (rdata),
        .stall         (stall),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_we    (mem_req_we),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wdata (mem_req_wdata),
        .mem_req_be    (mem_req_be),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // One memory transaction: wait for valid, optionally hold ready low, accept, then respond.
    // ok drops if stall falls, the request wobbles while waiting, or valid never shows up.
    task automatic serve_beat(input logic [31:0] rsp, input int hold, input bit respond,
                              output logic [31:0] addr, output logic we, output logic [3:0] be,
                              output logic [31:0] wdata, output bit ok);
        int n;
        ok = 1'b1;
        n = 0;
        addr = '0;
        we = 1'b0;
        be = '0;
        wdata = '0;
        #1;
        while (mem_req_valid !== 1'b1 && n < 40) begin
            if (stall !== 1'b1) ok = 1'b0;
            @(negedge clk);
            #1;
            n++;
        end
        if (mem_req_valid !== 1'b1) begin
            ok = 1'b0;
            return;
        end
        addr = mem_req_addr;
        we = mem_req_we;
        be = mem_req_be;
        wdata = mem_req_wdata;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            #1;
            if (mem_req_valid !== 1'b1 || mem_req_addr !== addr || stall !== 1'b1) ok = 1'b0;
        end
        if (stall !== 1'b1) ok = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        #1;
        if (mem_req_valid !== 1'b0 || stall !== 1'b1) ok = 1'b0;
        if (respond) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data = rsp;
            @(negedge clk);
            mem_rsp_valid = 1'b0;
            mem_rsp_data = '0;
        end
    endtask

    task automatic do_fill(input logic [31:0] base, input int hold_beat, input int hold,
                           output logic [3:0][31:0] addrs, output bit ok);
        logic [31:0] a;
        logic [31:0] wd;
        logic        w;
        logic [3:0]  b;
        bit          beat_ok;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            serve_beat(base + 32'(i), (i == hold_beat) ? hold : 0, 1'b1, a, w, b, wd, beat_ok);
            addrs[i] = a;
            if (!beat_ok || w !== 1'b0 || b !== 4'hF) ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_rd = 1'b1;
        req_wr = 1'b1;
        req_addr = 32'h100;
        repeat (3) @(negedge clk);
        #1;
        compared++; if (stall !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_stall: got %b expected 0", stall); end
        compared++; if (rdata !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_rdata: got %h expected 0", rdata); end
        compared++; if ({mem_req_valid, mem_req_we, mem_req_be} !== 6'b0) begin mismatched++; $display("[TB] FAIL reset_mem_ctrl: got v=%b we=%b be=%h expected all 0", mem_req_valid, mem_req_we, mem_req_be); end
        compared++; if ({mem_req_addr, mem_req_wdata} !== 64'h0) begin mismatched++; $display("[TB] FAIL reset_mem_data: got addr=%h wdata=%h expected 0", mem_req_addr, mem_req_wdata); end
        @(negedge clk);
        rst_n = 1'b1;
        req_rd = 1'b0;
        req_wr = 1'b0;
        #1;
        compared++; if (stall !== 1'b0 || rdata !== 32'h0) begin mismatched++; $display("[TB] FAIL post_reset_idle: got stall=%b rdata=%h expected 0/0", stall, rdata); end
    endtask

    task automatic test_cold_load();
        logic [3:0][31:0] addrs;
        bit ok;
        @(negedge clk);
        req_rd = 1'b1;
        req_addr = 32'h100;
        #1;
        compared++; if (stall !== 1'b1) begin mismatched++; $display("[TB] FAIL cold_miss_stall: got %b expected 1", stall); end
        do_fill(32'hA0, -1, 0, addrs, ok);
        for (int i = 0; i < 4; i++) begin
            compared++; if (addrs[i] !== 32'h100 + 32'(4*i)) begin mismatched++; $display("[TB] FAIL cold_fill_addr%0d: got %h expected %h", i, addrs[i], 32'h100 + 32'(4*i)); end
        end
        compared++; if (ok !== 1'b1) begin mismatched++; $display("[TB] FAIL cold_fill_ctrl: got %b expected 1", ok); end
        #1;
        compared++; if (stall !== 1'b0 || rdata !== 32'hA0) begin mismatched++; $display("[TB] FAIL cold_done: got stall=%b rdata=%h expected 0/000000a0", stall, rdata); end
        @(negedge clk);
        req_addr = 32'h108;
        #1;
        compared++; if (stall !== 1'b0 || rdata !== 32'hA2) begin mismatched++; $display("[TB] FAIL hit_0x108: got stall=%b rdata=%h expected 0/000000a2", stall, rdata); end
        @(negedge clk);
        req_rd = 1'b0;
        #1;
        compared++; if (rdata !== 32'h0) begin mismatched++; $display("[TB] FAIL rdata_idle_zero: got %h expected 0", rdata); end
    endtask

    task automatic test_store_hit();
        logic [31:0] a;
        logic [31:0] wd;
        logic        w;
        logic [3:0]  b;
        bit          ok;
        @(negedge clk);
        req_wr = 1'b1;
        req_addr = 32'h104;
        req_be = 4'b0011;
        req_wdata = 32'hFFFF1234;
        #1;
        compared++; if (stall !== 1'b1) begin mismatched++; $display("[TB] FAIL store_hit_stall: got %b expected 1", stall); end
        serve_beat(32'h0, 0, 1'b1, a, w, b, wd, ok);
        compared++; if ({a, w, b, wd} !== {32'h104, 1'b1, 4'b0011, 32'hFFFF1234}) begin mismatched++; $display("[TB] FAIL store_hit_req: got addr=%h we=%b be=%b wdata=%h expected 104/1/0011/ffff1234", a, w, b, wd); end
        compared++; if (ok !== 1'b1) begin mismatched++; $display("[TB] FAIL store_hit_ctrl: got %b expected 1", ok); end
        #1;
        compared++; if (stall !== 1'b0) begin mismatched++; $display("[TB] FAIL store_done_stall: got %b expected 0", stall); end
        @(negedge clk);
        req_wr = 1'b0;
        req_rd = 1'b1;
        #1;
        compared++; if (stall !== 1'b0 || rdata !== 32'h00001234) begin mismatched++; $display("[TB] FAIL store_merge: got stall=%b rdata=%h expected 0/00001234", stall, rdata); end
        @(negedge clk);
        req_rd = 1'b0;
    endtask

    task automatic test_store_miss();
        logic [31:0] a;
        logic [31:0] wd;
        logic        w;
        logic [3:0]  b;
        bit          ok;
        logic [3:0][31:0] addrs;
        @(negedge clk);
        req_wr = 1'b1;
        req_addr = 32'h400;
        req_be = 4'hF;
        req_wdata = 32'h5555AAAA;
        serve_beat(32'h0, 0, 1'b1, a, w, b, wd, ok);
        compared++; if ({a, w, b, wd} !== {32'h400, 1'b1, 4'hF, 32'h5555AAAA}) begin mismatched++; $display("[TB] FAIL store_miss_req: got addr=%h we=%b be=%h wdata=%h expected 400/1/f/5555aaaa", a, w, b, wd); end
        compared++; if (ok !== 1'b1) begin mismatched++; $display("[TB] FAIL store_miss_ctrl: got %b expected 1", ok); end
        @(negedge clk);
        req_wr = 1'b0;
        req_rd = 1'b1;
        #1;
        compared++; if (stall !== 1'b1) begin mismatched++; $display("[TB] FAIL no_write_alloc: got stall=%b expected 1", stall); end
        do_fill(32'hB0, -1, 0, addrs, ok);
        compared++; if (addrs !== {32'h40C, 32'h408, 32'h404, 32'h400} || ok !== 1'b1) begin mismatched++; $display("[TB] FAIL miss_fill_0x400: got addrs=%h ok=%b expected 40c_408_404_400/1", addrs, ok); end
        #1;
        compared++; if (stall !== 1'b0 || rdata !== 32'hB0) begin mismatched++; $display("[TB] FAIL miss_done_0x400: got stall=%b rdata=%h expected 0/000000b0", stall, rdata); end
        @(negedge clk);
        req_rd = 1'b0;
    endtask

    task automatic test_conflict();
        logic [3:0][31:0] addrs;
        bit ok;
        @(negedge clk);
        req_rd = 1'b1;
        req_addr = 32'h100;
        #1;
        compared++; if (stall !== 1'b1) begin mismatched++; $display("[TB] FAIL conflict_0x100_miss: got %b expected 1", stall); end
        do_fill(32'hC0, -1, 0, addrs, ok);
        #1;
        compared++; if (rdata !== 32'hC0 || ok !== 1'b1) begin mismatched++; $display("[TB] FAIL conflict_0x100_done: got rdata=%h ok=%b expected 000000c0/1", rdata, ok); end
        @(negedge clk);
        req_addr = 32'h200;
        #1;
        compared++; if (stall !== 1'b1) begin mismatched++; $display("[TB] FAIL conflict_0x200_miss: got %b expected 1", stall); end
        do_fill(32'hD0, -1, 0, addrs, ok);
        compared++; if (addrs !== {32'h20C, 32'h208, 32'h204, 32'h200} || ok !== 1'b1) begin mismatched++; $display("[TB] FAIL conflict_fill_0x200: got addrs=%h ok=%b expected 20c_208_204_200/1", addrs, ok); end
        #1;
        compared++; if (rdata !== 32'hD0) begin mismatched++; $display("[TB] FAIL conflict_0x200_done: got %h expected 000000d0", rdata); end
        @(negedge clk);
        req_addr = 32'h100;
        #1;
        compared++; if (stall !== 1'b1) begin mismatched++; $display("[TB] FAIL evicted_0x100_miss: got %b expected 1", stall); end
        do_fill(32'hE0, -1, 0, addrs, ok);
        #1;
        compared++; if (rdata !== 32'hE0 || ok !== 1'b1) begin mismatched++; $display("[TB] FAIL evicted_0x100_done: got rdata=%h ok=%b expected 000000e0/1", rdata, ok); end
        @(negedge clk);
        req_rd = 1'b0;
    endtask

    task automatic test_ready_hold();
        logic [3:0][31:0] addrs;
        bit ok;
        @(negedge clk);
        req_rd = 1'b1;
        req_addr = 32'h200;
        do_fill(32'h50, -1, 0, addrs, ok);
        @(negedge clk);
        req_addr = 32'h10C;
        #1;
        compared++; if (stall !== 1'b1) begin mismatched++; $display("[TB] FAIL hold_miss: got %b expected 1", stall); end
        do_fill(32'hF0, 1, 5, addrs, ok);
        compared++; if (addrs[1] !== 32'h104) begin mismatched++; $display("[TB] FAIL hold_beat1_addr: got %h expected 00000104", addrs[1]); end
        compared++; if (ok !== 1'b1) begin mismatched++; $display("[TB] FAIL hold_stable: got %b expected 1", ok); end
        #1;
        compared++; if (stall !== 1'b0 || rdata !== 32'hF3) begin mismatched++; $display("[TB] FAIL hold_done: got stall=%b rdata=%h expected 0/000000f3", stall, rdata); end
        @(negedge clk);
        req_rd = 1'b0;
    endtask

    task automatic test_reset_and_flush();
        logic [3:0][31:0] addrs;
        logic [31:0] a;
        logic [31:0] wd;
        logic        w;
        logic [3:0]  b;
        bit          ok;
        bit          ok0;
        bit          ok1;
        @(negedge clk);
        req_rd = 1'b1;
        req_addr = 32'h300;
        serve_beat(32'h30, 0, 1'b1, a, w, b, wd, ok0);
        serve_beat(32'h31, 0, 1'b1, a, w, b, wd, ok1);
        serve_beat(32'h32, 0, 1'b0, a, w, b, wd, ok);
        compared++; if (a !== 32'h308 || !(ok0 && ok1 && ok)) begin mismatched++; $display("[TB] FAIL abort_beat2: got addr=%h ok=%b%b%b expected 308/111", a, ok0, ok1, ok); end
        rst_n = 1'b0;
        #1;
        compared++; if (mem_req_valid !== 1'b0 || stall !== 1'b0 || rdata !== 32'h0) begin mismatched++; $display("[TB] FAIL mid_reset: got valid=%b stall=%b rdata=%h expected 0/0/0", mem_req_valid, stall, rdata); end
        @(negedge clk);
        rst_n = 1'b1;
        req_addr = 32'h100;
        #1;
        compared++; if (stall !== 1'b1) begin mismatched++; $display("[TB] FAIL after_reset_miss: got %b expected 1", stall); end
        do_fill(32'h60, -1, 0, addrs, ok);
        compared++; if (addrs !== {32'h10C, 32'h108, 32'h104, 32'h100} || ok !== 1'b1) begin mismatched++; $display("[TB] FAIL after_reset_fill: got addrs=%h ok=%b expected 10c_108_104_100/1", addrs, ok); end
        #1;
        compared++; if (rdata !== 32'h60) begin mismatched++; $display("[TB] FAIL after_reset_done: got %h expected 00000060", rdata); end
        @(negedge clk);
        req_addr = 32'h110;
        do_fill(32'h70, -1, 0, addrs, ok);
        #1;
        compared++; if (rdata !== 32'h70 || ok !== 1'b1) begin mismatched++; $display("[TB] FAIL line1_fill: got rdata=%h ok=%b expected 00000070/1", rdata, ok); end
        @(negedge clk);
        flush = 1'b1;
        req_addr = 32'h108;
        #1;
        compared++; if (stall !== 1'b0 || rdata !== 32'h62) begin mismatched++; $display("[TB] FAIL flush_cycle_hit: got stall=%b rdata=%h expected 0/00000062", stall, rdata); end
        @(negedge clk);
        flush = 1'b0;
        req_addr = 32'h114;
        #1;
        compared++; if (stall !== 1'b1) begin mismatched++; $display("[TB] FAIL flushed_line1_miss: got %b expected 1", stall); end
        do_fill(32'h80, -1, 0, addrs, ok);
        #1;
        compared++; if (rdata !== 32'h81 || ok !== 1'b1) begin mismatched++; $display("[TB] FAIL flushed_line1_done: got rdata=%h ok=%b expected 00000081/1", rdata, ok); end
        @(negedge clk);
        req_addr = 32'h104;
        #1;
        compared++; if (stall !== 1'b1) begin mismatched++; $display("[TB] FAIL flushed_line0_miss: got %b expected 1", stall); end
        do_fill(32'h90, -1, 0, addrs, ok);
        #1;
        compared++; if (rdata !== 32'h91 || ok !== 1'b1) begin mismatched++; $display("[TB] FAIL flushed_line0_done: got rdata=%h ok=%b expected 00000091/1", rdata, ok); end
        @(negedge clk);
        req_rd = 1'b0;
    endtask

    initial begin
        compared = 0;
        mismatched = 0;
        rst_n = 1'b0;
        req_rd = 1'b0;
        req_wr = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        req_be = '0;
        flush = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data = '0;
        test_reset();
        test_cold_load();
        test_store_hit();
        test_store_miss();
        test_conflict();
        test_ready_hold();
        test_reset_and_flush();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
